lane_dly_move_ctrl: RTL and testbench
=====================================

// Module: lane_dly_move_ctrl
// PURPOSE
//  Sequences the LANECTRL delay-line control inputs for one DDR3 lane.
//  Accepts one request at a time to load or step the RX or TX DQS delay line by N taps.
//  Brackets every operation with HS_IO_CLK_PAUSE, spaces the MOVE strobes and aborts on
//  out-of-range. Sits between the lane training FSMs and the lane's PF_LANECTRL.
// PARAMETERS
//  PAUSE_SETUP  2  cycles HS_IO_CLK_PAUSE is high before the first LOAD/MOVE strobe (>=1)
//  PAUSE_HOLD   2  cycles HS_IO_CLK_PAUSE stays high after the last settle cycle (>=1)
//  MOVE_GAP     4  cycles from one MOVE strobe to the next; includes the strobe cycle (>=2)
// PORTS
//  FAB_CLK                    in   1  fabric clock; all logic is on its rising edge
//  RESET_N                    in   1  synchronous reset, active low
//  REQ_VALID                  in   1  request present
//  REQ_READY                  out  1  controller idle; request accepted when VALID&READY
//  REQ_SEL                    in   1  0 = RX DQS delay line, 1 = TX DQS delay line
//  REQ_LOAD                   in   1  1 = single LOAD strobe (REQ_STEPS, REQ_DIR ignored)
//  REQ_DIR                    in   1  direction for MOVE strobes, passed to DELAY_LINE_DIRECTION
//  REQ_STEPS                  in   8  number of MOVE strobes, 0..255
//  DONE                       out  1  one-cycle completion pulse
//  DONE_STEPS                 out  8  MOVE strobes actually issued; valid while DONE=1
//  DONE_OOR                   out  1  operation aborted on out-of-range; valid while DONE=1
//  BUSY                       out  1  ~REQ_READY
//  DELAY_LINE_SEL             out  1  to LANECTRL; held at latched REQ_SEL for the whole op
//  DELAY_LINE_DIRECTION       out  1  to LANECTRL; held at latched REQ_DIR for the whole op
//  DELAY_LINE_LOAD            out  1  to LANECTRL; one-cycle strobe
//  DELAY_LINE_MOVE            out  1  to LANECTRL; one-cycle strobe
//  HS_IO_CLK_PAUSE            out  1  to LANECTRL; pause request
//  RX_DELAY_LINE_OUT_OF_RANGE in   1  from LANECTRL
//  TX_DELAY_LINE_OUT_OF_RANGE in   1  from LANECTRL
// BEHAVIOUR
//  - Reset (RESET_N=0 at an edge): state IDLE, REQ_READY=1, all other outputs 0.
//    Reset mid-operation drops PAUSE, SEL and strobes at that edge; no DONE is issued.
//  - All outputs are registered.
//  - FSM states: IDLE, PAUSE, STROBE, GAP, HOLD, FIN.
//  - IDLE: REQ_READY=1. On accept (edge 0), latch SEL, DIR, LOAD and STEPS; clear the step counter.
//    Zero-step move (LOAD=0, STEPS=0): go directly to FIN; no PAUSE and no strobe;
//    DONE in cycle 1 with DONE_STEPS=0 and DONE_OOR=0.
//    Otherwise go to PAUSE.
//  - PAUSE: HS_IO_CLK_PAUSE=1. SEL and DIR are driven. Stay PAUSE_SETUP cycles, then go to STROBE.
//  - STROBE (1 cycle): LOAD op drives DELAY_LINE_LOAD=1; move op drives DELAY_LINE_MOVE=1
//    and increments the counter. Then go to GAP.
//  - GAP: MOVE_GAP-1 cycles. On the last GAP cycle, sample the OOR input selected by SEL:
//      OOR=1                  -> set the abort flag, go to HOLD
//      LOAD op or count==STEPS -> go to HOLD
//      otherwise              -> go to STROBE
//  - HOLD: HS_IO_CLK_PAUSE=1 for PAUSE_HOLD cycles, then go to FIN.
//  - FIN (1 cycle): PAUSE=0, DONE=1, DONE_STEPS=count, DONE_OOR=abort flag, REQ_READY=0.
//    Next state IDLE. DELAY_LINE_SEL and DELAY_LINE_DIRECTION return to 0 in IDLE.
//  - Latency, move op with defaults and STEPS=N>0:
//      accept at cycle 0; PAUSE cycles 1-2; MOVE strobes at 3+4k;
//      HOLD at 4N+3 and 4N+4; DONE at cycle 4N+5.
//  - Latency, LOAD op with defaults: LOAD strobe at cycle 3, DONE at cycle 9.
//  - REQ_VALID outside IDLE is ignored; the requester holds it until READY.
//    Back-to-back requests: next accept is the IDLE cycle after FIN.
//  - STEPS=255 runs the full count; the 8-bit counter never wraps.
// TESTING
//  - Reset, then idle: REQ_READY=1; PAUSE, MOVE, LOAD, SEL and DONE all 0.
//    Assert RESET_N=0 during GAP -> all outputs 0 at the next edge.
//  - TX move, DIR=1, STEPS=3, defaults -> PAUSE high cycles 1-16; MOVE at 3, 7, 11; SEL=1, DIR=1 held;
//    DONE at 17 with DONE_STEPS=3, DONE_OOR=0.
//  - RX LOAD -> LOAD strobe at cycle 3; MOVE never asserted; DONE at 9 with DONE_STEPS=0.
//  - RX move STEPS=10, RX_OOR raised after the 2nd strobe -> exactly 2 strobes;
//    DONE_STEPS=2, DONE_OOR=1; PAUSE held through HOLD.
//    Same case with TX_OOR raised -> no abort; all 10 strobes issued.
//  - STEPS=0 (LOAD=0) -> DONE at cycle 1; PAUSE never asserted.
//    Requests during BUSY -> not accepted, and no strobe is issued for them.
//  - Back-to-back RX STEPS=1 then TX STEPS=1 -> second accept is the cycle after the first DONE;
//    SEL changes only while IDLE.

Source files
------------

// File: rtl/lane_dly_move_ctrl.sv
// lane_dly_move_ctrl
//   Sequences the PF_LANECTRL delay-line controls for one DDR3 lane. It takes one
//   request at a time to LOAD, or to MOVE the RX/TX DQS delay line by N taps. Each
//   operation is bracketed by HS_IO_CLK_PAUSE. MOVE strobes are spaced MOVE_GAP
//   cycles apart, and the operation aborts when the selected line reports
//   out-of-range.
//
// Ports
//   FAB_CLK, RESET_N            clock; synchronous active-low reset
//   REQ_VALID/REQ_READY         request handshake (accepted on VALID & READY)
//   REQ_SEL/LOAD/DIR/STEPS      line select, load/move, move direction, move count
//   DONE, DONE_STEPS, DONE_OOR  one-cycle completion pulse with strobe count and abort flag
//   BUSY                        inverse of REQ_READY
//   DELAY_LINE_*                LANECTRL delay-line controls (SEL, DIRECTION, LOAD, MOVE)
//   HS_IO_CLK_PAUSE             LANECTRL clock pause request
//   RX/TX_DELAY_LINE_OUT_OF_RANGE  out-of-range flags from LANECTRL
module lane_dly_move_ctrl #(
  parameter int PAUSE_SETUP = 2,
  parameter int PAUSE_HOLD  = 2,
  parameter int MOVE_GAP    = 4
) (
  input  logic       FAB_CLK,
  input  logic       RESET_N,
  input  logic       REQ_VALID,
  output logic       REQ_READY,
  input  logic       REQ_SEL,
  input  logic       REQ_LOAD,
  input  logic       REQ_DIR,
  input  logic [7:0] REQ_STEPS,
  output logic       DONE,
  output logic [7:0] DONE_STEPS,
  output logic       DONE_OOR,
  output logic       BUSY,
  output logic       DELAY_LINE_SEL,
  output logic       DELAY_LINE_DIRECTION,
  output logic       DELAY_LINE_LOAD,
  output logic       DELAY_LINE_MOVE,
  output logic       HS_IO_CLK_PAUSE,
  input  logic       RX_DELAY_LINE_OUT_OF_RANGE,
  input  logic       TX_DELAY_LINE_OUT_OF_RANGE
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PAUSE  = 3'd1,
    S_STROBE = 3'd2,
    S_GAP    = 3'd3,
    S_HOLD   = 3'd4,
    S_FIN    = 3'd5
  } state_t;

  // The wait timer is loaded with (length - 1) on entry and counts down to zero.
  localparam logic [7:0] SETUP_LAST = 8'(PAUSE_SETUP - 1);
  localparam logic [7:0] GAP_LAST   = 8'(MOVE_GAP - 2);
  localparam logic [7:0] HOLD_LAST  = 8'(PAUSE_HOLD - 1);

  state_t     state_q, state_d;
  logic [7:0] tmr_q, tmr_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] tgt_q, tgt_d;
  logic       sel_q, sel_d;
  logic       dir_q, dir_d;
  logic       load_q, load_d;
  logic       abort_q, abort_d;

  logic       ready_q, ready_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [7:0] done_steps_q, done_steps_d;
  logic       done_oor_q, done_oor_d;
  logic       dl_sel_q, dl_sel_d;
  logic       dl_dir_q, dl_dir_d;
  logic       dl_load_q, dl_load_d;
  logic       dl_move_q, dl_move_d;
  logic       pause_q, pause_d;

  logic       oor_in;
  logic       tmr_zero;

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    cnt_d   = cnt_q;
    tgt_d   = tgt_q;
    sel_d   = sel_q;
    dir_d   = dir_q;
    load_d  = load_q;
    abort_d = abort_q;

    oor_in   = sel_q ? TX_DELAY_LINE_OUT_OF_RANGE : RX_DELAY_LINE_OUT_OF_RANGE;
    tmr_zero = (tmr_q == '0);

    unique case (state_q)
      S_IDLE: begin
        if (REQ_VALID) begin
          sel_d   = REQ_SEL;
          dir_d   = REQ_DIR;
          load_d  = REQ_LOAD;
          tgt_d   = REQ_STEPS;
          cnt_d   = '0;
          abort_d = 1'b0;
          if (!REQ_LOAD && (REQ_STEPS == '0)) begin
            state_d = S_FIN;
          end else begin
            state_d = S_PAUSE;
            tmr_d   = SETUP_LAST;
          end
        end
      end
      S_PAUSE: begin
        if (tmr_zero) state_d = S_STROBE;
        else          tmr_d   = tmr_q - 8'd1;
      end
      S_STROBE: begin
        if (!load_q) cnt_d = cnt_q + 8'd1;
        state_d = S_GAP;
        tmr_d   = GAP_LAST;
      end
      S_GAP: begin
        if (tmr_zero) begin
          // Out-of-range takes priority, even on the final strobe.
          if (oor_in) begin
            abort_d = 1'b1;
            state_d = S_HOLD;
            tmr_d   = HOLD_LAST;
          end else if (load_q || (cnt_q == tgt_q)) begin
            state_d = S_HOLD;
            tmr_d   = HOLD_LAST;
          end else begin
            state_d = S_STROBE;
          end
        end else begin
          tmr_d = tmr_q - 8'd1;
        end
      end
      S_HOLD: begin
        if (tmr_zero) state_d = S_FIN;
        else          tmr_d   = tmr_q - 8'd1;
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so that every port comes straight from a flop.
  always_comb begin
    ready_d      = (state_d == S_IDLE);
    busy_d       = (state_d != S_IDLE);
    done_d       = (state_d == S_FIN);
    done_steps_d = (state_d == S_FIN) ? cnt_d : '0;
    done_oor_d   = (state_d == S_FIN) ? abort_d : 1'b0;
    dl_sel_d     = (state_d != S_IDLE) ? sel_d : 1'b0;
    dl_dir_d     = (state_d != S_IDLE) ? dir_d : 1'b0;
    dl_load_d    = (state_d == S_STROBE) && load_d;
    dl_move_d    = (state_d == S_STROBE) && !load_d;
    pause_d      = (state_d == S_PAUSE) || (state_d == S_STROBE) ||
                   (state_d == S_GAP)   || (state_d == S_HOLD);
  end

  always_ff @(posedge FAB_CLK) begin
    if (!RESET_N) begin
      state_q      <= S_IDLE;
      tmr_q        <= '0;
      cnt_q        <= '0;
      tgt_q        <= '0;
      sel_q        <= 1'b0;
      dir_q        <= 1'b0;
      load_q       <= 1'b0;
      abort_q      <= 1'b0;
      ready_q      <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      done_steps_q <= '0;
      done_oor_q   <= 1'b0;
      dl_sel_q     <= 1'b0;
      dl_dir_q     <= 1'b0;
      dl_load_q    <= 1'b0;
      dl_move_q    <= 1'b0;
      pause_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      tmr_q        <= tmr_d;
      cnt_q        <= cnt_d;
      tgt_q        <= tgt_d;
      sel_q        <= sel_d;
      dir_q        <= dir_d;
      load_q       <= load_d;
      abort_q      <= abort_d;
      ready_q      <= ready_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      done_steps_q <= done_steps_d;
      done_oor_q   <= done_oor_d;
      dl_sel_q     <= dl_sel_d;
      dl_dir_q     <= dl_dir_d;
      dl_load_q    <= dl_load_d;
      dl_move_q    <= dl_move_d;
      pause_q      <= pause_d;
    end
  end

  assign REQ_READY            = ready_q;
  assign BUSY                 = busy_q;
  assign DONE                 = done_q;
  assign DONE_STEPS           = done_steps_q;
  assign DONE_OOR             = done_oor_q;
  assign DELAY_LINE_SEL       = dl_sel_q;
  assign DELAY_LINE_DIRECTION = dl_dir_q;
  assign DELAY_LINE_LOAD      = dl_load_q;
  assign DELAY_LINE_MOVE      = dl_move_q;
  assign HS_IO_CLK_PAUSE      = pause_q;

endmodule

// File: tb/tb_lane_dly_move_ctrl.sv
// Testbench for lane_dly_move_ctrl: directed table of requests, hand-written
// reset / back-to-back sequences, then random traffic against a timeline model.
module tb_lane_dly_move_ctrl;

  localparam int PS = 2;
  localparam int PH = 2;
  localparam int G  = 4;
  localparam int S  = PS + 1;  // cycle of the first strobe after accept

  logic       FAB_CLK = 1'b0;
  logic       RESET_N;
  logic       REQ_VALID;
  logic       REQ_READY;
  logic       REQ_SEL;
  logic       REQ_LOAD;
  logic       REQ_DIR;
  logic [7:0] REQ_STEPS;
  logic       DONE;
  logic [7:0] DONE_STEPS;
  logic       DONE_OOR;
  logic       BUSY;
  logic       DELAY_LINE_SEL;
  logic       DELAY_LINE_DIRECTION;
  logic       DELAY_LINE_LOAD;
  logic       DELAY_LINE_MOVE;
  logic       HS_IO_CLK_PAUSE;
  logic       RX_OOR;
  logic       TX_OOR;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 FAB_CLK = ~FAB_CLK;

  lane_dly_move_ctrl #(.PAUSE_SETUP(PS), .PAUSE_HOLD(PH), .MOVE_GAP(G)) dut (
    .FAB_CLK                    (FAB_CLK),
    .RESET_N                    (RESET_N),
    .REQ_VALID                  (REQ_VALID),
    .REQ_READY                  (REQ_READY),
    .REQ_SEL                    (REQ_SEL),
    .REQ_LOAD                   (REQ_LOAD),
    .REQ_DIR                    (REQ_DIR),
    .REQ_STEPS                  (REQ_STEPS),
    .DONE                       (DONE),
    .DONE_STEPS                 (DONE_STEPS),
    .DONE_OOR                   (DONE_OOR),
    .BUSY                       (BUSY),
    .DELAY_LINE_SEL             (DELAY_LINE_SEL),
    .DELAY_LINE_DIRECTION       (DELAY_LINE_DIRECTION),
    .DELAY_LINE_LOAD            (DELAY_LINE_LOAD),
    .DELAY_LINE_MOVE            (DELAY_LINE_MOVE),
    .HS_IO_CLK_PAUSE            (HS_IO_CLK_PAUSE),
    .RX_DELAY_LINE_OUT_OF_RANGE (RX_OOR),
    .TX_DELAY_LINE_OUT_OF_RANGE (TX_OOR)
  );

  // {ready, busy, done, done_steps[7:0], done_oor, sel, dir, load, move, pause}
  localparam logic [16:0] IDLE_VEC = 17'h10000;

  function automatic logic [16:0] out_vec();
    return {REQ_READY, BUSY, DONE, DONE_STEPS, DONE_OOR, DELAY_LINE_SEL,
            DELAY_LINE_DIRECTION, DELAY_LINE_LOAD, DELAY_LINE_MOVE, HS_IO_CLK_PAUSE};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- directed table
  typedef struct {
    logic       sel;
    logic       load;
    logic       dir;
    logic [7:0] steps;
    int         oor_mode;   // 0 none, 1 raise RX OOR, 2 raise TX OOR
    int         oor_after;  // raise once this many MOVE strobes have been seen
    int         exp_done;
    int         exp_steps;
    logic       exp_oor;
    int         exp_moves;
    int         exp_loads;
    int         exp_pause;
    int         exp_first;
    int         exp_last;
  } vec_t;

  vec_t tbl[8];

  task automatic run_vec(input vec_t v);
    int   cyc;
    int   moves;
    int   loads;
    int   pauses;
    int   first_mv;
    int   last_mv;
    int   done_cyc;
    int   dsteps;
    logic door;
    logic held_ok;
    moves = 0; loads = 0; pauses = 0; first_mv = 0; last_mv = 0;
    done_cyc = -1; dsteps = -1; door = 1'bx; held_ok = 1'b1;
    @(negedge FAB_CLK);
    check("ready_before_req", 32'(REQ_READY), 32'd1);
    REQ_VALID = 1'b1; REQ_SEL = v.sel; REQ_LOAD = v.load; REQ_DIR = v.dir; REQ_STEPS = v.steps;
    @(negedge FAB_CLK);
    REQ_VALID = 1'b0;
    cyc = 1;
    while (cyc < 1200 && done_cyc < 0) begin
      if (DELAY_LINE_MOVE) begin
        moves++;
        if (first_mv == 0) first_mv = cyc;
        last_mv = cyc;
      end
      if (DELAY_LINE_LOAD) loads++;
      if (HS_IO_CLK_PAUSE) pauses++;
      if (DELAY_LINE_SEL !== v.sel || DELAY_LINE_DIRECTION !== v.dir || REQ_READY !== 1'b0)
        held_ok = 1'b0;
      if (DONE) begin
        done_cyc = cyc; dsteps = int'(DONE_STEPS); door = DONE_OOR;
      end
      if (v.oor_mode != 0 && moves >= v.oor_after) begin
        if (v.oor_mode == 1) RX_OOR = 1'b1;
        else                 TX_OOR = 1'b1;
      end
      if (done_cyc < 0) begin
        @(negedge FAB_CLK);
        cyc++;
      end
    end
    RX_OOR = 1'b0; TX_OOR = 1'b0;
    check("done_cycle", 32'(done_cyc), 32'(v.exp_done));
    check("done_steps", 32'(dsteps), 32'(v.exp_steps));
    check("done_oor", 32'(door), 32'(v.exp_oor));
    check("move_count", 32'(moves), 32'(v.exp_moves));
    check("load_count", 32'(loads), 32'(v.exp_loads));
    check("pause_cycles", 32'(pauses), 32'(v.exp_pause));
    check("first_move", 32'(first_mv), 32'(v.exp_first));
    check("last_move", 32'(last_mv), 32'(v.exp_last));
    check("sel_dir_held", 32'(held_ok), 32'd1);
  endtask

  // ---------------------------------------------------------------- timeline model
  // An operation is a timeline measured in cycles since accept: strobes at S+G*j,
  // OOR sampled in the last gap cycle S+G*j+G-1, hold after the last gap, done after hold.
  bit   m_act;
  int   m_k;
  int   m_m;
  logic m_ld, m_sl, m_dr, m_ab, m_zero;

  function automatic int m_fin();
    return m_zero ? 1 : (S + G * m_m + PH);
  endfunction

  function automatic logic [16:0] model_vec();
    int         fin;
    logic       done, ld, mv, pz;
    logic [7:0] cnt;
    if (!m_act) return IDLE_VEC;
    fin  = m_fin();
    done = (m_k == fin);
    cnt  = m_ld ? 8'd0 : 8'(m_m);
    pz   = !m_zero && (m_k < fin);
    ld   = m_ld && (m_k == S);
    mv   = !m_ld && !m_zero && (m_k >= S) && (m_k < S + G * m_m) && (((m_k - S) % G) == 0);
    return {1'b0, 1'b1, done, done ? cnt : 8'd0, done ? m_ab : 1'b0, m_sl, m_dr, ld, mv, pz};
  endfunction

  task automatic model_step(input logic rst_n, input logic valid, input logic sel,
                            input logic load, input logic dir, input logic [7:0] steps,
                            input logic rx, input logic tx);
    if (!rst_n) begin
      m_act = 1'b0;
    end else if (!m_act) begin
      if (valid) begin
        m_act = 1'b1; m_k = 1; m_ld = load; m_sl = sel; m_dr = dir; m_ab = 1'b0;
        m_zero = !load && (steps == 8'd0);
        m_m = load ? 1 : int'(steps);
      end
    end else begin
      if (!m_zero && m_k >= S && ((m_k - S) % G) == G - 1 && (m_k - S) / G < m_m) begin
        if (m_sl ? tx : rx) begin
          m_m  = (m_k - S) / G + 1;
          m_ab = 1'b1;
        end
      end
      if (m_k == m_fin()) m_act = 1'b0;
      else                m_k++;
    end
  endtask

  // ---------------------------------------------------------------- main
  initial begin : main
    int   cyc;
    int   cnt_a;
    int   cnt_b;
    int   first_done;
    int   second_done;
    int   first_steps;
    int   ready_cyc;
    int   sel1_cyc;
    logic seen_ready;
    logic sel_early_ok;

    RESET_N = 1'b0; REQ_VALID = 1'b0; REQ_SEL = 1'b0; REQ_LOAD = 1'b0; REQ_DIR = 1'b0;
    REQ_STEPS = 8'd0; RX_OOR = 1'b0; TX_OOR = 1'b0;
    m_act = 1'b0; m_k = 0; m_m = 0; m_ld = 0; m_sl = 0; m_dr = 0; m_ab = 0; m_zero = 0;

    tbl[0] = '{1'b1, 1'b0, 1'b1, 8'd3,   0, 0, 17,   3,   1'b0, 3,   0, 16,   3, 11};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 8'd7,   0, 0, 9,    0,   1'b0, 0,   1, 8,    0, 0};
    tbl[2] = '{1'b0, 1'b0, 1'b0, 8'd10,  1, 2, 13,   2,   1'b1, 2,   0, 12,   3, 7};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 8'd10,  2, 2, 45,   10,  1'b0, 10,  0, 44,   3, 39};
    tbl[4] = '{1'b0, 1'b0, 1'b0, 8'd0,   0, 0, 1,    0,   1'b0, 0,   0, 0,    0, 0};
    tbl[5] = '{1'b1, 1'b0, 1'b0, 8'd255, 0, 0, 1025, 255, 1'b0, 255, 0, 1024, 3, 1019};
    tbl[6] = '{1'b1, 1'b1, 1'b0, 8'd0,   2, 0, 9,    0,   1'b1, 0,   1, 8,    0, 0};
    tbl[7] = '{1'b0, 1'b0, 1'b1, 8'd1,   1, 1, 9,    1,   1'b1, 1,   0, 8,    3, 3};

    repeat (2) @(negedge FAB_CLK);
    check("reset_state", 32'(out_vec()), 32'(IDLE_VEC));
    RESET_N = 1'b1;
    @(negedge FAB_CLK);
    check("idle_after_reset", 32'(out_vec()), 32'(IDLE_VEC));

    for (int i = 0; i < 8; i++) run_vec(tbl[i]);

    // Reset asserted during GAP: everything drops at the next edge and no DONE follows.
    @(negedge FAB_CLK);
    REQ_VALID = 1'b1; REQ_SEL = 1'b1; REQ_LOAD = 1'b0; REQ_DIR = 1'b1; REQ_STEPS = 8'd3;
    @(negedge FAB_CLK);
    REQ_VALID = 1'b0;
    repeat (4) @(negedge FAB_CLK);
    check("pause_in_gap", 32'(HS_IO_CLK_PAUSE), 32'd1);
    RESET_N = 1'b0;
    @(negedge FAB_CLK);
    check("reset_mid_gap", 32'(out_vec()), 32'(IDLE_VEC));
    RESET_N = 1'b1;
    cnt_a = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge FAB_CLK);
      if (DONE || HS_IO_CLK_PAUSE || DELAY_LINE_MOVE) cnt_a++;
    end
    check("quiet_after_reset", 32'(cnt_a), 32'd0);

    // Back-to-back: VALID held through BUSY with a different request waiting behind it.
    @(negedge FAB_CLK);
    REQ_VALID = 1'b1; REQ_SEL = 1'b0; REQ_LOAD = 1'b0; REQ_DIR = 1'b0; REQ_STEPS = 8'd1;
    @(negedge FAB_CLK);
    REQ_SEL = 1'b1; REQ_DIR = 1'b1; REQ_LOAD = 1'b0; REQ_STEPS = 8'd1;
    cnt_a = 0; cnt_b = 0; first_done = -1; second_done = -1; first_steps = -1;
    ready_cyc = -1; sel1_cyc = -1; seen_ready = 1'b0; sel_early_ok = 1'b1;
    for (cyc = 1; cyc <= 40 && second_done < 0; cyc++) begin
      if (DELAY_LINE_MOVE) cnt_a++;
      if (DELAY_LINE_LOAD) cnt_b++;
      if (DONE) begin
        if (first_done < 0) begin
          first_done = cyc; first_steps = int'(DONE_STEPS);
        end else begin
          second_done = cyc;
        end
      end
      if (REQ_READY && ready_cyc < 0) ready_cyc = cyc;
      if (DELAY_LINE_SEL && sel1_cyc < 0) sel1_cyc = cyc;
      if (cyc <= 10 && DELAY_LINE_SEL !== 1'b0) sel_early_ok = 1'b0;
      if (REQ_READY) seen_ready = 1'b1;
      if (seen_ready && BUSY) REQ_VALID = 1'b0;
      if (second_done < 0) @(negedge FAB_CLK);
    end
    REQ_VALID = 1'b0;
    check("b2b_first_done", 32'(first_done), 32'd9);
    check("b2b_first_steps", 32'(first_steps), 32'd1);
    check("b2b_ready_cycle", 32'(ready_cyc), 32'd10);
    check("b2b_sel_first_cycle", 32'(sel1_cyc), 32'd11);
    check("b2b_sel_low_first_op", 32'(sel_early_ok), 32'd1);
    check("b2b_second_done", 32'(second_done), 32'd19);
    check("b2b_move_count", 32'(cnt_a), 32'd2);
    check("b2b_load_count", 32'(cnt_b), 32'd0);

    // Random traffic against the timeline model; the first cycle forces a reset to align.
    @(negedge FAB_CLK);
    for (int i = 0; i < 4000; i++) begin
      if (i > 0) check("random_cycle", 32'(out_vec()), 32'(model_vec()));
      RESET_N   = (i == 0) ? 1'b0 : ($urandom_range(0, 299) != 0);
      REQ_VALID = ($urandom_range(0, 2) == 0);
      REQ_SEL   = 1'($urandom_range(0, 1));
      REQ_LOAD  = ($urandom_range(0, 3) == 0);
      REQ_DIR   = 1'($urandom_range(0, 1));
      REQ_STEPS = 8'($urandom_range(0, 5));
      RX_OOR    = ($urandom_range(0, 5) == 0);
      TX_OOR    = ($urandom_range(0, 5) == 0);
      model_step(RESET_N, REQ_VALID, REQ_SEL, REQ_LOAD, REQ_DIR, REQ_STEPS, RX_OOR, TX_OOR);
      @(negedge FAB_CLK);
    end
    check("random_final", 32'(out_vec()), 32'(model_vec()));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
